// File: rtl/msg_serializer.sv
// Message-to-AXI-Stream serializer: captures one message of up to MAX_MSG_BYTES bytes
// and emits it as DATA_BYTES-wide beats with tkeep/tlast/tuser qualifiers.
module msg_serializer #(
   parameter int unsigned MAX_MSG_BYTES = 32,
   parameter int unsigned DATA_BYTES    = 8,
   parameter int unsigned TKEEP_WIDTH   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       msg_valid,
   output logic                       msg_ready,
   input  logic [15:0]                msg_length,
   input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
   input  logic                       msg_error,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic                       m_tlast,
   output logic [8*DATA_BYTES-1:0]    m_tdata,
   output logic [TKEEP_WIDTH-1:0]     m_tkeep,
   output logic                       m_tuser
);

   localparam int unsigned MSG_W   = 8 * MAX_MSG_BYTES;
   localparam int unsigned TDATA_W = 8 * DATA_BYTES;
   localparam int unsigned CNT_W   = $clog2(MAX_MSG_BYTES / DATA_BYTES) + 1;

   typedef enum logic {IDLE, SEND} state_t;

   typedef struct packed {
      logic [TDATA_W-1:0]    data;
      logic [DATA_BYTES-1:0] keep;
      logic                  last;
      logic                  user;
   } beat_t;

   state_t             state;
   logic [MSG_W-1:0]   data_q;
   logic [15:0]        len_q;
   logic               err_q;
   logic [CNT_W-1:0]   cnt;
   beat_t              first_beat;
   beat_t              next_beat;

   // Build beat k of a message; illegal lengths collapse to a single null beat.
   function automatic beat_t make_beat(input logic [MSG_W-1:0] data,
                                       input logic [15:0]      len,
                                       input logic             err,
                                       input logic [CNT_W-1:0] k);
      beat_t              b;
      logic [16:0]        base;
      logic [TDATA_W-1:0] window;
      logic [TDATA_W-1:0] bytemask;
      b        = '0;
      bytemask = '0;
      base     = 17'(k) * 17'(DATA_BYTES);
      window   = TDATA_W'(data >> (base * 17'd8));
      if (len == 16'd0 || 17'(len) > 17'(MAX_MSG_BYTES)) begin
         b.last = 1'b1;
         b.user = 1'b1;
      end else begin
         for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            if (base + 17'(i) < 17'(len)) begin
               b.keep   |= DATA_BYTES'(1) << i;
               bytemask |= TDATA_W'(8'hFF) << (8 * i);
            end
         end
         b.data = window & bytemask;
         b.last = (17'(len) <= base + 17'(DATA_BYTES));
         b.user = b.last & err;
      end
      return b;
   endfunction

   assign first_beat = make_beat(msg_data, msg_length, msg_error, '0);
   assign next_beat  = make_beat(data_q, len_q, err_q, cnt + CNT_W'(1));

   // Control FSM with all stream outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         msg_ready <= 1'b0;
         m_tvalid  <= 1'b0;
         m_tlast   <= 1'b0;
         m_tuser   <= 1'b0;
         m_tkeep   <= '0;
         m_tdata   <= '0;
         cnt       <= '0;
         data_q    <= '0;
         len_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (msg_valid && msg_ready) begin
                  data_q    <= msg_data;
                  len_q     <= msg_length;
                  err_q     <= msg_error;
                  cnt       <= '0;
                  msg_ready <= 1'b0;
                  m_tvalid  <= 1'b1;
                  m_tdata   <= first_beat.data;
                  m_tkeep   <= TKEEP_WIDTH'(first_beat.keep);
                  m_tlast   <= first_beat.last;
                  m_tuser   <= first_beat.user;
                  state     <= SEND;
               end else begin
                  msg_ready <= 1'b1;
               end
            end
            SEND: begin
               if (m_tready) begin
                  if (m_tlast) begin
                     state     <= IDLE;
                     msg_ready <= 1'b1;
                     m_tvalid  <= 1'b0;
                     m_tlast   <= 1'b0;
                     m_tuser   <= 1'b0;
                     m_tkeep   <= '0;
                     m_tdata   <= '0;
                  end else begin
                     cnt     <= cnt + CNT_W'(1);
                     m_tdata <= next_beat.data;
                     m_tkeep <= TKEEP_WIDTH'(next_beat.keep);
                     m_tlast <= next_beat.last;
                     m_tuser <= next_beat.user;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msg_serializer.sv
// Bench for msg_serializer: directed scenarios plus random traffic, all beats checked
// by a queue-based scoreboard fed from a byte-level reference model.
module tb_msg_serializer;

   localparam int MAXB = 32;
   localparam int DB   = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         msg_valid;
   logic         msg_ready;
   logic [15:0]  msg_length;
   logic [255:0] msg_data;
   logic         msg_error;
   logic         m_tvalid;
   logic         m_tready;
   logic         m_tlast;
   logic [63:0]  m_tdata;
   logic [7:0]   m_tkeep;
   logic         m_tuser;

   always #5 clk = ~clk;

   msg_serializer #(.MAX_MSG_BYTES(32), .DATA_BYTES(8), .TKEEP_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_length(msg_length),
      .msg_data(msg_data), .msg_error(msg_error),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   beat_t exp_q[$];
   int    vectors     = 0;
   int    errors      = 0;
   int    hs_count    = 0;
   int    tready_mode = 0;
   logic  held_v      = 1'b0;
   beat_t held;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference model: slice the message byte by byte into 8-byte beats.
   function automatic void push_expected(input int len, input logic [255:0] d, input logic err);
      beat_t        e;
      logic [255:0] t;
      if (len == 0 || len > MAXB) begin
         e      = '0;
         e.last = 1'b1;
         e.user = 1'b1;
         exp_q.push_back(e);
         return;
      end
      for (int k = 0; k * DB < len; k++) begin
         e = '0;
         for (int i = 0; i < DB; i++) begin
            if (k * DB + i < len) begin
               t = d >> (8 * (k * DB + i));
               e.data |= 64'(t[7:0]) << (8 * i);
               e.keep |= 8'(1) << i;
            end
         end
         e.last = ((k + 1) * DB >= len);
         e.user = e.last & err;
         exp_q.push_back(e);
      end
   endfunction

   function automatic logic [255:0] rand_data();
      logic [255:0] r = '0;
      for (int j = 0; j < 8; j++) r = (r << 32) | 256'($urandom);
      return r;
   endfunction

   // Monitor: compares each handshaken beat with the scoreboard, and checks holds under stall.
   always @(negedge clk) begin
      beat_t act;
      beat_t e;
      act = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            check("hold_tvalid", 64'(m_tvalid), 64'd1);
            check("hold_tdata", m_tdata, held.data);
            check("hold_keep_last_user", 64'({m_tkeep, m_tlast, m_tuser}),
                  64'({held.keep, held.last, held.user}));
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_beat: got data %h keep %h, required no beat", m_tdata, m_tkeep);
            end else begin
               e = exp_q.pop_front();
               check("beat_tdata", m_tdata, e.data);
               check("beat_tkeep", 64'(m_tkeep), 64'(e.keep));
               check("beat_tlast", 64'(m_tlast), 64'(e.last));
               check("beat_tuser", 64'(m_tuser), 64'(e.user));
            end
            hs_count++;
            held_v = 1'b0;
         end else begin
            held_v = m_tvalid;
            held   = act;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (tready_mode == 1) m_tready = ($urandom_range(0, 3) != 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_msg(input int len, input logic [255:0] d, input logic err);
      int waited = 0;
      msg_valid  = 1'b1;
      msg_length = 16'(len);
      msg_data   = d;
      msg_error  = err;
      while (!msg_ready && waited < 300) begin
         tick();
         waited++;
      end
      if (!msg_ready) begin
         vectors++;
         errors++;
         $display("FAIL accept_timeout: got msg_ready 0, required 1");
         msg_valid = 1'b0;
         return;
      end
      push_expected(len, d, err);
      tick();
      msg_valid  = 1'b0;
      msg_data   = {8{$urandom}};
      msg_length = 16'($urandom);
      msg_error  = 1'($urandom);
      check("accept_tvalid", 64'(m_tvalid), 64'd1);
      check("accept_msg_ready", 64'(msg_ready), 64'd0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || !msg_ready) && n < 500) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0 || !msg_ready) begin
         vectors++;
         errors++;
         $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] d;
      int           h0;
      rst        = 1'b1;
      msg_valid  = 1'b0;
      msg_length = '0;
      msg_data   = '0;
      msg_error  = 1'b0;
      m_tready   = 1'b1;
      repeat (3) tick();
      check("reset_msg_ready", 64'(msg_ready), 64'd0);
      check("reset_tvalid", 64'(m_tvalid), 64'd0);
      check("reset_tdata", m_tdata, 64'd0);
      check("reset_keep_last_user", 64'({m_tkeep, m_tlast, m_tuser}), 64'd0);
      rst = 1'b0;
      tick();
      check("post_reset_msg_ready", 64'(msg_ready), 64'd1);

      // Full 32-byte message at full throughput.
      send_msg(32, rand_data(), 1'b0);
      for (int c = 0; c < 4; c++) begin
         check("full_tvalid", 64'(m_tvalid), 64'd1);
         check("full_tlast", 64'(m_tlast), 64'(c == 3));
         tick();
      end
      check("full_ready_after", 64'(msg_ready), 64'd1);
      check("full_tvalid_after", 64'(m_tvalid), 64'd0);

      // 13-byte message with a partial final beat.
      d = rand_data();
      for (int i = 0; i < 13; i++)
         d = (d & ~(256'hFF << (8 * i))) | (256'(i) << (8 * i));
      send_msg(13, d, 1'b0);
      check("partial_b0_data", m_tdata, 64'h0706050403020100);
      check("partial_b0_keep", 64'(m_tkeep), 64'hFF);
      tick();
      check("partial_b1_data", m_tdata, 64'h0000000C0B0A0908);
      check("partial_b1_keep", 64'(m_tkeep), 64'h1F);
      check("partial_b1_last", 64'(m_tlast), 64'd1);
      wait_idle();

      // Backpressure on beat 1 of a 24-byte message.
      h0 = hs_count;
      send_msg(24, rand_data(), 1'b0);
      tick();
      m_tready = 1'b0;
      repeat (3) tick();
      m_tready = 1'b1;
      wait_idle();
      check("bp_beat_count", 64'(hs_count - h0), 64'd3);

      // Error flag on a single short beat.
      send_msg(5, rand_data(), 1'b1);
      check("err_keep", 64'(m_tkeep), 64'h1F);
      check("err_last_user", 64'({m_tlast, m_tuser}), 64'b11);
      wait_idle();

      // Illegal lengths yield one null beat each.
      send_msg(0, rand_data(), 1'b0);
      check("len0_keep_data", 64'(m_tkeep) | m_tdata, 64'd0);
      wait_idle();
      send_msg(40, rand_data(), 1'b0);
      check("len40_last_user", 64'({m_tlast, m_tuser}), 64'b11);
      wait_idle();

      // Reset in the middle of a message.
      h0 = hs_count;
      send_msg(32, rand_data(), 1'b0);
      while (hs_count < h0 + 2 && hs_count < h0 + 100) tick();
      rst      = 1'b1;
      m_tready = 1'b0;
      check("mid_reset_pending", 64'(exp_q.size()), 64'd2);
      exp_q.delete();
      tick();
      check("mid_reset_tvalid", 64'(m_tvalid), 64'd0);
      check("mid_reset_msg_ready", 64'(msg_ready), 64'd0);
      rst = 1'b0;
      tick();
      check("after_reset_msg_ready", 64'(msg_ready), 64'd1);
      m_tready = 1'b1;
      send_msg(8, rand_data(), 1'b0);
      wait_idle();

      // Random traffic with random backpressure.
      tready_mode = 1;
      for (int n = 0; n < 40; n++)
         send_msg($urandom_range(0, 40), rand_data(), 1'($urandom_range(0, 1)));
      wait_idle();
      tready_mode = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
